lcd_text_feeder: RTL and testbench



---
 rtl/lcd_text_feeder_if.sv | 29 ++
 rtl/lcd_text_feeder.sv | 259 +++++++++++++++++++++++++
 tb/tb_lcd_text_feeder.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_text_feeder_if.sv
// lcd_text_feeder_if: op bus between the text feeder and the LCD 1602A
// controller.
//   lcd_rdy     controller ready (controller -> feeder)
//   lcd_enable  one-cycle op strobe (feeder -> controller)
//   lcd_op      one-hot op code, NCOMMANDS+1 bits
//   lcd_data    character code for WRITE, 0 otherwise
// The master modport is the feeder side; the slave modport is the controller side.
interface lcd_text_feeder_if #(
  parameter int NCOMMANDS = 5
) ();
  logic                 lcd_rdy;
  logic                 lcd_enable;
  logic [NCOMMANDS:0]   lcd_op;
  logic [7:0]           lcd_data;

  modport master (
    input  lcd_rdy,
    output lcd_enable,
    output lcd_op,
    output lcd_data
  );

  modport slave (
    output lcd_rdy,
    input  lcd_enable,
    input  lcd_op,
    input  lcd_data
  );
endinterface

// File: rtl/lcd_text_feeder.sv
// lcd_text_feeder: holds a 2x16 character frame buffer and replays it to the
// LCD 1602A controller as a command/character stream.
// Ports:
//   clk, rst                synchronous active-high reset
//   wr_en/wr_addr/wr_data   host buffer write; index 0-15 is line 0, 16-31 is line 1
//   refresh                 single-cycle redraw request
//   busy                    sequence in progress
//   done                    one-cycle pulse when a sequence completes
//   lcd                     controller op bus (strobe/op/data out, ready in)
// A redraw is CLEAR, 16 line-0 chars, PAD_LEN blanks (to move DDRAM from 0x10
// to 0x40), then 16 line-1 chars. The post-reset sequence is a single INIT.
module lcd_text_feeder #(
  parameter int                 NCOMMANDS    = 5,
  parameter logic [NCOMMANDS:0] OP_INIT      = 6'b000001,
  parameter logic [NCOMMANDS:0] OP_CLEAR     = 6'b000010,
  parameter logic [NCOMMANDS:0] OP_WRITE     = 6'b000100,
  parameter int                 LINE_LEN     = 16,
  parameter int                 PAD_LEN      = 24,
  parameter int                 BUSY_TIMEOUT = 8,
  parameter int                 AUTO_INIT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              refresh,
  output logic              busy,
  output logic              done,
  lcd_text_feeder_if.master lcd
);

  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_BUSY, ST_WAIT_RDY} state_e;
  typedef enum logic [2:0] {PH_INIT, PH_CLEAR, PH_L0, PH_PAD, PH_L1} phase_e;

  localparam phase_e PH_START = (AUTO_INIT != 0) ? PH_INIT : PH_CLEAR;

  state_e             state_q, state_d;
  phase_e             phase_q, phase_d;
  logic [5:0]         idx_q, idx_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               pending_q, pending_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               lcd_enable_q, lcd_enable_d;
  logic [NCOMMANDS:0] lcd_op_q, lcd_op_d;
  logic [7:0]         lcd_data_q, lcd_data_d;
  logic [7:0]         buf_q [32];
  logic [7:0]         buf_d [32];

  logic               op_done_s;
  logic               last_op_s;
  logic [5:0]         phase_last_s;
  logic [NCOMMANDS:0] issue_op_s;
  logic [7:0]         issue_data_s;

  // Phase order of a sequence; INIT and L1 are terminal and fall back to CLEAR.
  function automatic phase_e next_phase(input phase_e ph);
    case (ph)
      PH_INIT:  next_phase = PH_CLEAR;
      PH_CLEAR: next_phase = PH_L0;
      PH_L0:    next_phase = PH_PAD;
      PH_PAD:   next_phase = PH_L1;
      default:  next_phase = PH_CLEAR;
    endcase
  endfunction

  // Last index of the current phase, op code and payload for the current index.
  always_comb begin
    phase_last_s = 6'd0;
    issue_op_s   = OP_WRITE;
    issue_data_s = 8'h00;
    case (phase_q)
      PH_INIT: begin
        issue_op_s = OP_INIT;
      end
      PH_CLEAR: begin
        issue_op_s = OP_CLEAR;
      end
      PH_L0: begin
        phase_last_s = 6'(LINE_LEN - 1);
        issue_data_s = buf_q[idx_q[4:0]];
      end
      PH_PAD: begin
        phase_last_s = 6'(PAD_LEN - 1);
        issue_data_s = 8'h20;
      end
      PH_L1: begin
        phase_last_s = 6'(LINE_LEN - 1);
        issue_data_s = buf_q[5'(LINE_LEN) + idx_q[4:0]];
      end
      default: begin
        phase_last_s = 6'd0;
      end
    endcase
  end

  assign last_op_s = (idx_q == phase_last_s) && ((phase_q == PH_INIT) || (phase_q == PH_L1));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; an op completes on ready after busy, or on busy timeout.
  always_comb begin
    state_d   = state_q;
    op_done_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q || refresh) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (lcd.lcd_rdy) begin
          state_d = ST_WAIT_BUSY;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT_BUSY: begin
        if (!lcd.lcd_rdy) begin
          state_d = ST_WAIT_RDY;
        end else if (tmo_q == TMO_LAST) begin
          op_done_s = 1'b1;
          state_d   = last_op_s ? ST_IDLE : ST_ISSUE;
        end else begin
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_RDY: begin
        if (lcd.lcd_rdy) begin
          op_done_s = 1'b1;
          state_d   = last_op_s ? ST_IDLE : ST_ISSUE;
        end else begin
          state_d = ST_WAIT_RDY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs and sequencing datapath.
  always_comb begin
    phase_d      = phase_q;
    idx_d        = idx_q;
    tmo_d        = tmo_q;
    pending_d    = pending_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    lcd_enable_d = 1'b0;
    lcd_op_d     = lcd_op_q;
    lcd_data_d   = lcd_data_q;

    // Starting a sequence consumes any pending request; further requests while
    // busy collapse into one pending redraw.
    if ((state_q == ST_IDLE) && (state_d == ST_ISSUE)) begin
      busy_d    = 1'b1;
      pending_d = 1'b0;
    end else if (busy_q && refresh) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    if ((state_q == ST_ISSUE) && lcd.lcd_rdy) begin
      lcd_enable_d = 1'b1;
      lcd_op_d     = issue_op_s;
      lcd_data_d   = issue_data_s;
      tmo_d        = '0;
    end else if ((state_q == ST_WAIT_BUSY) && lcd.lcd_rdy && !op_done_s) begin
      tmo_d = tmo_q + TW'(1);
    end else begin
      tmo_d = tmo_q;
    end

    if (op_done_s) begin
      if (idx_q == phase_last_s) begin
        idx_d   = 6'd0;
        phase_d = next_phase(phase_q);
      end else begin
        idx_d = idx_q + 6'd1;
      end
      if (last_op_s) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        done_d = 1'b0;
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Sequencing and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= PH_START;
      idx_q        <= 6'd0;
      tmo_q        <= '0;
      pending_q    <= (AUTO_INIT != 0);
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      lcd_enable_q <= 1'b0;
      lcd_op_q     <= '0;
      lcd_data_q   <= 8'h00;
    end else begin
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      tmo_q        <= tmo_d;
      pending_q    <= pending_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      lcd_enable_q <= lcd_enable_d;
      lcd_op_q     <= lcd_op_d;
      lcd_data_q   <= lcd_data_d;
    end
  end

  // Host write port; a read in the same cycle sees the previous contents.
  always_comb begin
    buf_d = buf_q;
    if (wr_en) begin
      buf_d[wr_addr] = wr_data;
    end else begin
      buf_d = buf_q;
    end
  end

  // Frame buffer storage, cleared to spaces on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        buf_q[i] <= 8'h20;
      end
    end else begin
      buf_q <= buf_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign lcd.lcd_enable = lcd_enable_q;
  assign lcd.lcd_op     = lcd_op_q;
  assign lcd.lcd_data   = lcd_data_q;

endmodule

// File: tb/tb_lcd_text_feeder.sv
module tb_lcd_text_feeder;
  localparam logic [5:0] OP_INIT  = 6'b000001;
  localparam logic [5:0] OP_CLEAR = 6'b000010;
  localparam logic [5:0] OP_WRITE = 6'b000100;
  localparam int         LOGN     = 1024;

  typedef struct packed {
    logic [5:0] op;
    logic [7:0] data;
  } strobe_t;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
    int         strobe_no;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       refresh;
  logic       busy;
  logic       done;

  lcd_text_feeder_if #(.NCOMMANDS(5)) lcd ();

  lcd_text_feeder #(
    .NCOMMANDS(5), .OP_INIT(OP_INIT), .OP_CLEAR(OP_CLEAR), .OP_WRITE(OP_WRITE),
    .LINE_LEN(16), .PAD_LEN(24), .BUSY_TIMEOUT(8), .AUTO_INIT(1)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .refresh(refresh), .busy(busy), .done(done), .lcd(lcd)
  );

  always #25 clk = ~clk;

  int        checks = 0;
  int        errors = 0;
  int        cyc = 0;
  int        n_strobe = 0;
  int        n_done = 0;
  int        ctl_cnt = 0;
  logic      ctl_always_rdy = 1'b0;
  logic      prev_en = 1'b0;
  strobe_t   sb_q[$];
  strobe_t   slog [LOGN];
  int        scyc [LOGN];
  logic [7:0] tb_buf [32];
  vec_t      vecs [10];

  function automatic strobe_t mk(input logic [5:0] op, input logic [7:0] data);
    strobe_t s;
    s.op   = op;
    s.data = data;
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  // One clock: controller model, protocol check and scoreboard, all at posedge+1.
  task automatic tick();
    strobe_t got_s;
    strobe_t exp_s;
    @(posedge clk);
    #1;
    cyc++;
    if (lcd.lcd_enable) ctl_cnt = 1;
    else if (ctl_cnt != 0) ctl_cnt++;
    if (ctl_cnt == 9) ctl_cnt = 0;
    lcd.lcd_rdy = ctl_always_rdy ? 1'b1 : (ctl_cnt < 4);
    if (lcd.lcd_enable) begin
      checks++;
      if (prev_en || !lcd.lcd_rdy) begin
        errors++;
        $display("FAIL strobe_protocol: strobe %0d prev_en=%0b rdy=%0b required 0 and 1",
                 n_strobe, prev_en, lcd.lcd_rdy);
      end
      got_s = mk(lcd.lcd_op, lcd.lcd_data);
      if (n_strobe < LOGN) begin
        slog[n_strobe] = got_s;
        scyc[n_strobe] = cyc;
      end
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: strobe %0d got op=%b data=%h required no strobe",
                 n_strobe, got_s.op, got_s.data);
      end else begin
        exp_s = sb_q.pop_front();
        if (got_s !== exp_s) begin
          errors++;
          $display("FAIL sb_strobe: strobe %0d got op=%b data=%h required op=%b data=%h",
                   n_strobe, got_s.op, got_s.data, exp_s.op, exp_s.data);
        end
      end
      n_strobe++;
    end
    prev_en = lcd.lcd_enable;
    if (done) n_done++;
  endtask

  task automatic push_refresh();
    sb_q.push_back(mk(OP_CLEAR, 8'h00));
    for (int i = 0; i < 16; i++) sb_q.push_back(mk(OP_WRITE, tb_buf[i]));
    for (int i = 0; i < 24; i++) sb_q.push_back(mk(OP_WRITE, 8'h20));
    for (int i = 16; i < 32; i++) sb_q.push_back(mk(OP_WRITE, tb_buf[i]));
  endtask

  task automatic pulse_refresh();
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
  endtask

  task automatic host_write(input logic [4:0] addr, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tb_buf[addr] = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic wait_strobes(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (n_strobe < target && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_strobes_reached"}, 32'(n_strobe >= target), 32'd1);
  endtask

  initial begin
    int base;
    int dbase;
    int nbad;
    rst = 1'b1;
    wr_en = 1'b0;
    wr_addr = 5'd0;
    wr_data = 8'h00;
    refresh = 1'b0;
    lcd.lcd_rdy = 1'b1;
    for (int i = 0; i < 32; i++) tb_buf[i] = 8'h20;
    vecs = '{
      '{5'd0,  8'h48, 2},  '{5'd1,  8'h45, 3},  '{5'd2,  8'h4C, 4},
      '{5'd3,  8'h4C, 5},  '{5'd4,  8'h4F, 6},  '{5'd16, 8'h57, 42},
      '{5'd17, 8'h4F, 43}, '{5'd18, 8'h52, 44}, '{5'd19, 8'h4C, 45},
      '{5'd20, 8'h44, 46}
    };

    // Reset state.
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_enable", 32'(lcd.lcd_enable), 32'd0);
    chk("rst_op", 32'(lcd.lcd_op), 32'd0);
    chk("rst_data", 32'(lcd.lcd_data), 32'd0);

    // Automatic INIT after reset.
    sb_q.push_back(mk(OP_INIT, 8'h00));
    base = n_strobe;
    dbase = n_done;
    rst = 1'b0;
    tick();
    chk("autoinit_busy_rise", 32'(busy), 32'd1);
    wait_done("autoinit", 500);
    chk("autoinit_busy_fall", 32'(busy), 32'd0);
    repeat (20) tick();
    chk("autoinit_strobes", 32'(n_strobe - base), 32'd1);
    chk("autoinit_dones", 32'(n_done - dbase), 32'd1);
    chk("autoinit_sb_empty", 32'(sb_q.size()), 32'd0);

    // HELLO / WORLD redraw, spot-checked against the vector table.
    for (int i = 0; i < 10; i++) host_write(vecs[i].addr, vecs[i].data);
    base = n_strobe;
    push_refresh();
    pulse_refresh();
    chk("refresh_busy_next", 32'(busy), 32'd1);
    chk("refresh_no_strobe_yet", 32'(n_strobe - base), 32'd0);
    wait_done("hello", 2000);
    chk("hello_strobes", 32'(n_strobe - base), 32'd57);
    chk("hello_first_op", 32'(slog[base].op), 32'(OP_CLEAR));
    for (int i = 0; i < 10; i++)
      chk($sformatf("hello_vec%0d", i), 32'(slog[base + vecs[i].strobe_no - 1].data),
          32'(vecs[i].data));
    nbad = 0;
    for (int s = 18; s <= 41; s++) if (slog[base + s - 1].data !== 8'h20) nbad++;
    chk("hello_pad_blank", 32'(nbad), 32'd0);
    nbad = 0;
    for (int s = 2; s <= 57; s++) if (slog[base + s - 1].op !== OP_WRITE) nbad++;
    chk("hello_write_ops", 32'(nbad), 32'd0);

    // Repeated refresh while busy collapses into one more sequence; then a
    // refresh on the done cycle starts yet another one immediately.
    base = n_strobe;
    dbase = n_done;
    push_refresh();
    pulse_refresh();
    wait_strobes("multi", base + 10, 500);
    push_refresh();
    for (int k = 0; k < 3; k++) begin
      pulse_refresh();
      repeat (3) tick();
    end
    wait_done("multi_first", 2000);
    tick();
    chk("multi_pending_restart", 32'(busy), 32'd1);
    wait_done("multi_second", 2000);
    push_refresh();
    pulse_refresh();
    chk("done_cycle_refresh_busy", 32'(busy), 32'd1);
    wait_done("multi_third", 2000);
    repeat (40) tick();
    chk("multi_idle", 32'(busy), 32'd0);
    chk("multi_strobes", 32'(n_strobe - base), 32'd171);
    chk("multi_dones", 32'(n_done - dbase), 32'd3);
    chk("multi_sb_empty", 32'(sb_q.size()), 32'd0);

    // Controller never drops ready: every op ends by timeout.
    ctl_always_rdy = 1'b1;
    lcd.lcd_rdy = 1'b1;
    base = n_strobe;
    push_refresh();
    pulse_refresh();
    wait_done("tmo", 2000);
    chk("tmo_strobes", 32'(n_strobe - base), 32'd57);
    chk("tmo_gap_first", 32'(scyc[base + 1] - scyc[base]), 32'd9);
    nbad = 0;
    for (int i = 1; i < 57; i++) if (scyc[base + i] - scyc[base + i - 1] != 9) nbad++;
    chk("tmo_gap_all", 32'(nbad), 32'd0);
    ctl_always_rdy = 1'b0;
    repeat (5) tick();

    // Write to the last line-1 slot while line 0 is being sent.
    base = n_strobe;
    push_refresh();
    pulse_refresh();
    wait_strobes("late_wr", base + 5, 500);
    host_write(5'd31, 8'h41);
    sb_q[sb_q.size() - 1] = mk(OP_WRITE, 8'h41);
    wait_done("late_wr", 2000);
    chk("late_wr_last", 32'(slog[base + 56].data), 32'h41);

    // Reset in the middle of a redraw.
    repeat (5) tick();
    base = n_strobe;
    push_refresh();
    pulse_refresh();
    wait_strobes("midrst", base + 20, 1000);
    rst = 1'b1;
    tick();
    chk("midrst_enable", 32'(lcd.lcd_enable), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_op", 32'(lcd.lcd_op), 32'd0);
    sb_q.delete();
    sb_q.push_back(mk(OP_INIT, 8'h00));
    for (int i = 0; i < 32; i++) tb_buf[i] = 8'h20;
    rst = 1'b0;
    tick();
    chk("midrst_busy_rise", 32'(busy), 32'd1);
    wait_done("midrst_init", 500);
    chk("midrst_strobes", 32'(n_strobe - base), 32'd21);
    chk("midrst_init_op", 32'(slog[base + 20].op), 32'(OP_INIT));
    repeat (10) tick();
    base = n_strobe;
    push_refresh();
    pulse_refresh();
    wait_done("midrst_blank", 2000);
    chk("midrst_buf_h", 32'(slog[base + 1].data), 32'h20);
    chk("midrst_buf_w", 32'(slog[base + 41].data), 32'h20);
    chk("midrst_buf_last", 32'(slog[base + 56].data), 32'h20);
    repeat (5) tick();
    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
